// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register bank two registers per capture and streams {addr,data} beats.
// Optional macro CHECKSUM_EN adds dump_csum_o, the XOR of every transferred beat since start.
module reg_dump_reader #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rf_addr_a_o,
    output logic [ADDR_W-1:0] rf_addr_b_o,
    input  logic [DATA_W-1:0] rf_data_a_i,
    input  logic [DATA_W-1:0] rf_data_b_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              done_o
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] dump_csum_o
`endif
);

    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pair_q, pair_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] ent_addr_q [2];
    logic [ADDR_W-1:0] ent_addr_d [2];
    logic [DATA_W-1:0] ent_data_q [2];
    logic [DATA_W-1:0] ent_data_d [2];

    logic              pop;
    logic              capture;
    logic              start_acc;
    logic              last_pair;
    logic              wr_slot;
    logic [ADDR_W-1:0] head_addr;

    // State register
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_READ;
            ST_READ:  if (capture && last_pair) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && dump_last_o) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o = (state_q == ST_READ) || (state_q == ST_DRAIN);
        done_o = (state_q == ST_DONE);
    end

    // Read ports, FIFO head and capture/pop control
    always_comb begin
        start_acc    = (state_q == ST_IDLE) && start_i;
        last_pair    = (pair_q == LAST_PAIR);
        rf_addr_a_o  = pair_q;
        rf_addr_b_o  = pair_q + ADDR_W'(1);
        head_addr    = ent_addr_q[rd_ptr_q];
        dump_valid_o = (count_q != 2'd0);
        dump_addr_o  = dump_valid_o ? head_addr : '0;
        dump_data_o  = dump_valid_o ? ent_data_q[rd_ptr_q] : '0;
        dump_last_o  = dump_valid_o && (head_addr == LAST_ADDR);
        pop          = dump_valid_o && dump_ready_i;
        capture      = (state_q == ST_READ) &&
                       ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
        // Pairs are always written together, so the free slot is head + occupancy.
        wr_slot      = rd_ptr_q ^ count_q[0];
    end

    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        pair_d     = pair_q;
        count_d    = count_q - {1'b0, pop} + {capture, 1'b0};
        rd_ptr_d   = rd_ptr_q ^ pop;
        if (start_acc) begin
            pair_d = '0;
        end else if (capture) begin
            pair_d = last_pair ? '0 : pair_q + ADDR_W'(2);
        end
        if (capture) begin
            ent_addr_d[wr_slot]  = pair_q;
            ent_data_d[wr_slot]  = rf_data_a_i;
            ent_addr_d[~wr_slot] = rf_addr_b_o;
            ent_data_d[~wr_slot] = rf_data_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pair_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            pair_q     <= pair_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q ^ dump_data_o;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign dump_csum_o = csum_q;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: scoreboard of expected beats plus timing/reset sequences.
// Compiles checksum checks only when CHECKSUM_EN is defined, matching the RTL build.
module tb_reg_dump_reader;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          nrst_i;
    logic          start_i;
    logic [AW-1:0] rf_addr_a_o, rf_addr_b_o;
    logic [DW-1:0] rf_data_a_i, rf_data_b_i;
    logic          dump_valid_o;
    logic          dump_ready_i;
    logic [AW-1:0] dump_addr_o;
    logic [DW-1:0] dump_data_o;
    logic          dump_last_o;
    logic          busy_o;
    logic          done_o;
`ifdef CHECKSUM_EN
    logic [DW-1:0] dump_csum_o;
`endif

    logic [DW-1:0] bank     [NR];
    logic [DW-1:0] exp_data [NR];

    int checks = 0;
    int errors = 0;

    logic          rec_v [64];
    logic [AW-1:0] rec_a [64];
    logic          rec_l [64];
    logic          rec_b [64];
    logic          rec_d [64];

    typedef struct {
        int            off;
        logic          valid;
        logic [AW-1:0] addr;
        logic          last;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t tab [9];

    always #5 clk = ~clk;

    assign rf_data_a_i = bank[rf_addr_a_o];
    assign rf_data_b_i = bank[rf_addr_b_o];

    reg_dump_reader #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_REGS(NR)
    ) dut (
        .clk_i       (clk),
        .nrst_i      (nrst_i),
        .start_i     (start_i),
        .rf_addr_a_o (rf_addr_a_o),
        .rf_addr_b_o (rf_addr_b_o),
        .rf_data_a_i (rf_data_a_i),
        .rf_data_b_i (rf_data_b_i),
        .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i),
        .dump_addr_o (dump_addr_o),
        .dump_data_o (dump_data_o),
        .dump_last_o (dump_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef CHECKSUM_EN
        ,
        .dump_csum_o (dump_csum_o)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete dump. Expected beats come from a snapshot of the bank taken at start:
    // addresses 0..NR-1 in order, each exactly once, plus the handshake rules.
    task automatic run_dump(input int ready_pct, input bit spurious, input bit do_writes);
        int            idx;
        bit            held;
        bit            seen_done;
        bit            wrote;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        logic [DW-1:0] xr;
        idx = 0; held = 0; seen_done = 0; wrote = 0; xr = '0;
        h_addr = '0; h_data = '0;
        for (int k = 0; k < NR; k++) exp_data[k] = bank[k];
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            next_cycle();
            start_i      = (cyc == 0) || (spurious && (idx == 5 || idx == 20 || idx == NR));
            dump_ready_i = ($urandom_range(0, 99) < ready_pct);
            if (do_writes && idx >= 2 && !wrote) begin
                bank[30]     = 64'h0000_0000_DEAD_BEEF;
                bank[0]      = 64'h1234;
                exp_data[30] = 64'h0000_0000_DEAD_BEEF;
                wrote        = 1;
            end
            @(negedge clk);
            if (cyc < 64) begin
                rec_v[cyc] = dump_valid_o; rec_a[cyc] = dump_addr_o; rec_l[cyc] = dump_last_o;
                rec_b[cyc] = busy_o;       rec_d[cyc] = done_o;
            end
`ifdef CHECKSUM_EN
            if (cyc == 1) chk("csum_cleared", dump_csum_o, 64'h0);
`endif
            if (cyc > 0) chk("busy", busy_o, 64'(idx < NR));
            chk("done", done_o, 64'(idx == NR));
            if (idx == NR) begin
`ifdef CHECKSUM_EN
                chk("csum_done", dump_csum_o, xr);
`endif
                chk("valid_in_done", dump_valid_o, 64'h0);
                seen_done = 1;
            end else if (dump_valid_o) begin
                if (held) begin
                    chk("hold_addr", dump_addr_o, h_addr);
                    chk("hold_data", dump_data_o, h_data);
                end
                if (dump_ready_i) begin
                    chk("beat_addr", dump_addr_o, 64'(idx));
                    chk("beat_data", dump_data_o, exp_data[idx]);
                    chk("beat_last", dump_last_o, 64'(idx == NR - 1));
                    xr  = xr ^ exp_data[idx];
                    idx++;
                    held = 0;
                end else begin
                    held   = 1;
                    h_addr = dump_addr_o;
                    h_data = dump_data_o;
                end
            end else if (held) begin
                chk("valid_dropped", dump_valid_o, 64'h1);
                held = 0;
            end
        end
        if (!seen_done) chk("dump_timeout", 64'(idx), 64'(NR + 1));
        next_cycle();
        start_i      = 0;
        dump_ready_i = 0;
        if (spurious) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("idle_busy", busy_o, 64'h0);
                chk("idle_valid", dump_valid_o, 64'h0);
                next_cycle();
            end
        end
`ifdef CHECKSUM_EN
        @(negedge clk);
        chk("csum_hold", dump_csum_o, xr);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Timing table for a full-rate dump; offsets are cycles after the start cycle.
        tab[0] = '{off: 0,  valid: 0, addr: 0,  last: 0, busy: 0, done: 0};
        tab[1] = '{off: 1,  valid: 0, addr: 0,  last: 0, busy: 1, done: 0};
        tab[2] = '{off: 2,  valid: 1, addr: 0,  last: 0, busy: 1, done: 0};
        tab[3] = '{off: 3,  valid: 1, addr: 1,  last: 0, busy: 1, done: 0};
        tab[4] = '{off: 17, valid: 1, addr: 15, last: 0, busy: 1, done: 0};
        tab[5] = '{off: 32, valid: 1, addr: 30, last: 0, busy: 1, done: 0};
        tab[6] = '{off: 33, valid: 1, addr: 31, last: 1, busy: 1, done: 0};
        tab[7] = '{off: 34, valid: 0, addr: 0,  last: 0, busy: 0, done: 1};
        tab[8] = '{off: 35, valid: 0, addr: 0,  last: 0, busy: 0, done: 0};

        nrst_i = 0; start_i = 0; dump_ready_i = 0;
        for (int k = 0; k < NR; k++) bank[k] = 64'(k * 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", dump_valid_o, 64'h0);
        chk("rst_busy", busy_o, 64'h0);
        chk("rst_addr_a", rf_addr_a_o, 64'h0);
        chk("rst_addr_b", rf_addr_b_o, 64'h1);
        nrst_i = 1;

        // Reset in the middle of a dump, while beat 10 is presented.
        next_cycle();
        start_i = 1; dump_ready_i = 1;
        n = 0;
        do begin
            next_cycle();
            start_i = 0;
            @(negedge clk);
            n++;
        end while (!(dump_valid_o && dump_addr_o == 5'd10) && n < 100);
        chk("reach_beat10", 64'(n < 100), 64'h1);
        #1 nrst_i = 0;
        #1;
        chk("midrst_valid", dump_valid_o, 64'h0);
        chk("midrst_addr", dump_addr_o, 64'h0);
        chk("midrst_data", dump_data_o, 64'h0);
        chk("midrst_last", dump_last_o, 64'h0);
        chk("midrst_busy", busy_o, 64'h0);
        chk("midrst_done", done_o, 64'h0);
        chk("midrst_addr_a", rf_addr_a_o, 64'h0);
        chk("midrst_addr_b", rf_addr_b_o, 64'h1);
        repeat (2) @(negedge clk);
        nrst_i = 1;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            chk("post_rst_done", done_o, 64'h0);
            chk("post_rst_busy", busy_o, 64'h0);
        end

        // Full-rate dump, then the cycle-exact timing table.
        run_dump(100, 0, 0);
        for (int i = 0; i < $size(tab); i++) begin
            n = tab[i].off;
            chk($sformatf("t%0d_valid", n), rec_v[n], tab[i].valid);
            chk($sformatf("t%0d_busy", n), rec_b[n], tab[i].busy);
            chk($sformatf("t%0d_done", n), rec_d[n], tab[i].done);
            if (tab[i].valid) begin
                chk($sformatf("t%0d_addr", n), rec_a[n], tab[i].addr);
                chk($sformatf("t%0d_last", n), rec_l[n], tab[i].last);
            end
        end

        // Backpressure with random bank contents.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NR; k++) bank[k] = {$urandom, $urandom};
            run_dump(50, 0, 0);
        end

        // Starts during busy and during DONE are ignored; a fresh start restarts at addr 0.
        run_dump(100, 1, 0);
        run_dump(70, 0, 0);

        // Writes during a dump: reg 30 before capture, reg 0 after capture.
        for (int k = 0; k < NR; k++) bank[k] = 64'(k * 3);
        run_dump(100, 0, 1);

`ifdef CHECKSUM_EN
        for (int k = 0; k < NR; k++) bank[k] = 64'h1 << k;
        run_dump(100, 0, 0);
        chk("csum_final", dump_csum_o, 64'h0000_0000_FFFF_FFFF);
        run_dump(100, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
